// File: rtl/noise_estimation_block_stats_pkg.sv
// Shared defaults, FSM state type and accumulator width helpers for the
// noise-estimation block statistics unit.
package noise_est_pkg;

  localparam int unsigned PIXEL_WIDTH_DEFAULT = 8;
  localparam int unsigned BLOCK_SIZE_DEFAULT  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // log2 of the number of pixels in one block (BLOCK_SIZE is a power of two)
  function automatic int unsigned log2_n(input int unsigned bs);
    return $clog2(bs * bs);
  endfunction

  function automatic int unsigned sum_width(input int unsigned pw, input int unsigned bs);
    return pw + log2_n(bs);
  endfunction

  function automatic int unsigned sumsq_width(input int unsigned pw, input int unsigned bs);
    return 2 * pw + log2_n(bs);
  endfunction

endpackage

// File: rtl/noise_estimation_block_stats_if.sv
// Frame control, pixel stream and result bus of the block statistics unit.
interface noise_estimation_block_stats_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PIXEL_WIDTH = 8
);
  logic [15:0]              frame_height;
  logic [15:0]              frame_width;
  logic                     start_of_frame;
  logic                     noise_estimation_en;
  logic [DATA_WIDTH-1:0]    data_in;
  logic                     data_valid;
  logic [PIXEL_WIDTH-1:0]   block_mean;
  logic [2*PIXEL_WIDTH-1:0] block_var;
  logic                     block_valid;
  logic [2*PIXEL_WIDTH-1:0] noise_var;
  logic                     noise_valid;
  logic                     busy;

  modport master (
    output frame_height, frame_width, start_of_frame, noise_estimation_en,
           data_in, data_valid,
    input  block_mean, block_var, block_valid, noise_var, noise_valid, busy
  );

  modport slave (
    input  frame_height, frame_width, start_of_frame, noise_estimation_en,
           data_in, data_valid,
    output block_mean, block_var, block_valid, noise_var, noise_valid, busy
  );
endinterface

// File: rtl/noise_estimation_block_stats_block_variance_calc.sv
// Two-stage mean / variance pipeline for one completed block.
module block_variance_calc
  import noise_est_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = PIXEL_WIDTH_DEFAULT,
  parameter int unsigned BLOCK_SIZE  = BLOCK_SIZE_DEFAULT
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            flush,
  input  logic                                            in_valid,
  input  logic [sum_width(PIXEL_WIDTH, BLOCK_SIZE)-1:0]   sum,
  input  logic [sumsq_width(PIXEL_WIDTH, BLOCK_SIZE)-1:0] sumsq,
  output logic [PIXEL_WIDTH-1:0]                          block_mean,
  output logic [2*PIXEL_WIDTH-1:0]                        block_var,
  output logic                                            block_valid
);
  localparam int unsigned L     = log2_n(BLOCK_SIZE);
  localparam int unsigned VAR_W = 2 * PIXEL_WIDTH;

  logic                   s1_valid_q, s1_valid_d;
  logic [PIXEL_WIDTH-1:0] mean1_q, mean1_d;
  logic [VAR_W-1:0]       ex2_q, ex2_d;
  logic                   block_valid_q, block_valid_d;
  logic [PIXEL_WIDTH-1:0] block_mean_q, block_mean_d;
  logic [VAR_W-1:0]       block_var_q, block_var_d;
  logic [VAR_W-1:0]       mm_c;

  // Stage 1 divides by N; stage 2 forms E[x^2] - mean^2, floored at zero
  always_comb begin
    s1_valid_d    = in_valid & ~flush;
    mean1_d       = mean1_q;
    ex2_d         = ex2_q;
    if (in_valid) begin
      mean1_d = PIXEL_WIDTH'(sum >> L);
      ex2_d   = VAR_W'(sumsq >> L);
    end
    mm_c          = VAR_W'(mean1_q) * VAR_W'(mean1_q);
    block_valid_d = s1_valid_q & ~flush;
    block_mean_d  = block_mean_q;
    block_var_d   = block_var_q;
    if (s1_valid_q && !flush) begin
      block_mean_d = mean1_q;
      block_var_d  = (ex2_q >= mm_c) ? (ex2_q - mm_c) : '0;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      mean1_q       <= '0;
      ex2_q         <= '0;
      block_valid_q <= 1'b0;
      block_mean_q  <= '0;
      block_var_q   <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      mean1_q       <= mean1_d;
      ex2_q         <= ex2_d;
      block_valid_q <= block_valid_d;
      block_mean_q  <= block_mean_d;
      block_var_q   <= block_var_d;
    end
  end

  assign block_valid = block_valid_q;
  assign block_mean  = block_mean_q;
  assign block_var   = block_var_q;

endmodule

// File: rtl/noise_estimation_block_stats.sv
// Per-block mean/variance accumulation and minimum-variance frame noise estimate.
module noise_estimation_block_stats
  import noise_est_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PIXEL_WIDTH = PIXEL_WIDTH_DEFAULT,
  parameter int unsigned BLOCK_SIZE  = BLOCK_SIZE_DEFAULT
) (
  input logic                           clk,
  input logic                           rst_n,
  noise_estimation_block_stats_if.slave bus
);
  localparam int unsigned N     = BLOCK_SIZE * BLOCK_SIZE;
  localparam int unsigned L     = log2_n(BLOCK_SIZE);
  localparam int unsigned BS_SH = $clog2(BLOCK_SIZE);
  localparam int unsigned SUM_W = sum_width(PIXEL_WIDTH, BLOCK_SIZE);
  localparam int unsigned SQ_W  = sumsq_width(PIXEL_WIDTH, BLOCK_SIZE);
  localparam int unsigned VAR_W = 2 * PIXEL_WIDTH;
  localparam int unsigned CNT_W = 32;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   blocks_total_q, blocks_total_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   block_cnt_q, block_cnt_d;
  logic [VAR_W-1:0]   min_var_q, min_var_d;
  logic [L-1:0]       pix_cnt_q, pix_cnt_d;
  logic [SUM_W-1:0]   sum_q, sum_d, hand_sum_q, hand_sum_d;
  logic [SQ_W-1:0]    sumsq_q, sumsq_d, hand_sumsq_q, hand_sumsq_d;
  logic               hand_valid_q, hand_valid_d;
  logic [VAR_W-1:0]   noise_var_q, noise_var_d;
  logic               noise_valid_q, noise_valid_d;
  logic               busy_q, busy_d;

  logic               sof_c, accept_c, last_block_c;
  logic [CNT_W-1:0]   frame_total_c;
  logic [PIXEL_WIDTH-1:0] pix_c;
  logic [VAR_W-1:0]   pix_sq_c, min_c;
  logic               blk_valid;
  logic [PIXEL_WIDTH-1:0] blk_mean;
  logic [VAR_W-1:0]   blk_var;
  logic               unused_data_hi;

  assign unused_data_hi = ^bus.data_in[DATA_WIDTH-1:PIXEL_WIDTH];

  // Frame geometry, beat qualification and end-of-frame detection
  always_comb begin
    sof_c         = bus.start_of_frame;
    frame_total_c = CNT_W'(bus.frame_height >> BS_SH) * CNT_W'(bus.frame_width >> BS_SH);
    pix_c         = bus.data_in[PIXEL_WIDTH-1:0];
    pix_sq_c      = VAR_W'(pix_c) * VAR_W'(pix_c);
    accept_c      = (state_q == ACCUM) && bus.data_valid && bus.noise_estimation_en &&
                    (issued_q < blocks_total_q);
    last_block_c  = blk_valid && ((block_cnt_q + CNT_W'(1)) == blocks_total_q);
    min_c         = (blk_var < min_var_q) ? blk_var : min_var_q;
  end

  // Next-state logic; start_of_frame re-arms from any state
  always_comb begin
    state_d = state_q;
    if (sof_c) begin
      state_d = (frame_total_c == '0) ? DONE : ACCUM;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        ACCUM:   if (last_block_c) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered frame outputs: noise pulse coincides with the DONE cycle
  always_comb begin
    noise_valid_d = 1'b0;
    noise_var_d   = noise_var_q;
    busy_d        = (state_d == ACCUM);
    if (sof_c) begin
      if (frame_total_c == '0) begin
        noise_valid_d = 1'b1;
        noise_var_d   = '0;
      end
    end else if ((state_q == ACCUM) && last_block_c) begin
      noise_valid_d = 1'b1;
      noise_var_d   = min_c;
    end
  end

  // Accumulators, block hand-off and running minimum
  always_comb begin
    blocks_total_d = blocks_total_q;
    issued_d       = issued_q;
    block_cnt_d    = block_cnt_q;
    min_var_d      = min_var_q;
    pix_cnt_d      = pix_cnt_q;
    sum_d          = sum_q;
    sumsq_d        = sumsq_q;
    hand_valid_d   = 1'b0;
    hand_sum_d     = hand_sum_q;
    hand_sumsq_d   = hand_sumsq_q;
    if (sof_c) begin
      blocks_total_d = frame_total_c;
      issued_d       = '0;
      block_cnt_d    = '0;
      min_var_d      = '1;
      pix_cnt_d      = '0;
      sum_d          = '0;
      sumsq_d        = '0;
    end else begin
      if (accept_c) begin
        if (pix_cnt_q == L'(N - 1)) begin
          hand_valid_d = 1'b1;
          hand_sum_d   = sum_q + SUM_W'(pix_c);
          hand_sumsq_d = sumsq_q + SQ_W'(pix_sq_c);
          pix_cnt_d    = '0;
          sum_d        = '0;
          sumsq_d      = '0;
          issued_d     = issued_q + CNT_W'(1);
        end else begin
          pix_cnt_d = pix_cnt_q + L'(1);
          sum_d     = sum_q + SUM_W'(pix_c);
          sumsq_d   = sumsq_q + SQ_W'(pix_sq_c);
        end
      end
      if (blk_valid && (state_q == ACCUM)) begin
        min_var_d   = min_c;
        block_cnt_d = block_cnt_q + CNT_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocks_total_q <= '0;
      issued_q       <= '0;
      block_cnt_q    <= '0;
      min_var_q      <= '0;
      pix_cnt_q      <= '0;
      sum_q          <= '0;
      sumsq_q        <= '0;
      hand_valid_q   <= 1'b0;
      hand_sum_q     <= '0;
      hand_sumsq_q   <= '0;
      noise_var_q    <= '0;
      noise_valid_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      blocks_total_q <= blocks_total_d;
      issued_q       <= issued_d;
      block_cnt_q    <= block_cnt_d;
      min_var_q      <= min_var_d;
      pix_cnt_q      <= pix_cnt_d;
      sum_q          <= sum_d;
      sumsq_q        <= sumsq_d;
      hand_valid_q   <= hand_valid_d;
      hand_sum_q     <= hand_sum_d;
      hand_sumsq_q   <= hand_sumsq_d;
      noise_var_q    <= noise_var_d;
      noise_valid_q  <= noise_valid_d;
      busy_q         <= busy_d;
    end
  end

  block_variance_calc #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .BLOCK_SIZE  (BLOCK_SIZE)
  ) u_calc (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (sof_c),
    .in_valid    (hand_valid_q),
    .sum         (hand_sum_q),
    .sumsq       (hand_sumsq_q),
    .block_mean  (blk_mean),
    .block_var   (blk_var),
    .block_valid (blk_valid)
  );

  assign bus.block_mean  = blk_mean;
  assign bus.block_var   = blk_var;
  assign bus.block_valid = blk_valid;
  assign bus.noise_var   = noise_var_q;
  assign bus.noise_valid = noise_valid_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_noise_estimation_block_stats.sv
// Scoreboard bench: stimulus queues expected block/noise results, a monitor checks them.
module tb_noise_estimation_block_stats;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noise_estimation_block_stats_if #(.DATA_WIDTH(32), .PIXEL_WIDTH(8)) bus ();

  noise_estimation_block_stats #(
    .DATA_WIDTH  (32),
    .PIXEL_WIDTH (8),
    .BLOCK_SIZE  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_bv_cyc = -100;
  int beat16_cyc  = 0;

  int exp_mean_q[$];
  int exp_var_q[$];
  int exp_noise_q[$];
  bit exp_noise_lat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every result pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.block_valid) begin
        if (exp_mean_q.size() == 0) begin
          chk("block_unexpected", 1, 0);
        end else begin
          chk("block_mean", int'(bus.block_mean), exp_mean_q.pop_front());
          chk("block_var", int'(bus.block_var), exp_var_q.pop_front());
        end
        last_bv_cyc = cyc;
      end
      if (bus.noise_valid) begin
        if (exp_noise_q.size() == 0) begin
          chk("noise_unexpected", 1, 0);
        end else begin
          chk("noise_var", int'(bus.noise_var), exp_noise_q.pop_front());
          chk("busy_at_noise", int'(bus.busy), 0);
          if (exp_noise_lat_q.pop_front()) chk("noise_latency", cyc - last_bv_cyc, 1);
        end
      end
    end
  end

  task automatic push_blk(input int m, input int v);
    exp_mean_q.push_back(m);
    exp_var_q.push_back(v);
  endtask

  task automatic push_noise(input int v, input bit lat);
    exp_noise_q.push_back(v);
    exp_noise_lat_q.push_back(lat);
  endtask

  task automatic sof(input int h, input int w);
    bus.frame_height   = 16'(h);
    bus.frame_width    = 16'(w);
    bus.start_of_frame = 1'b1;
    @(negedge clk);
    bus.start_of_frame = 1'b0;
  endtask

  // One accepted beat; upper data bits carry junk that must be ignored
  task automatic beat(input int p);
    logic [31:0] r;
    r = $urandom;
    bus.data_in    = {r[31:8], 8'(p)};
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.data_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Valid beats with enable low: must not be counted
  task automatic paused(input int n);
    bus.noise_estimation_en = 1'b0;
    bus.data_in    = 32'd200;
    bus.data_valid = 1'b1;
    repeat (n) @(negedge clk);
    bus.data_valid = 1'b0;
    bus.noise_estimation_en = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_mean_q.size() != 0 || exp_noise_q.size() != 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", (k >= 400) ? 1 : 0, 0);
    repeat (6) @(negedge clk);
  endtask

  task automatic push_8x8();
    push_blk(8, 29);
    push_blk(24, 45);
    push_blk(40, 61);
    push_blk(56, 77);
    push_noise(29, 1'b1);
  endtask

  initial begin
    bus.frame_height        = '0;
    bus.frame_width         = '0;
    bus.start_of_frame      = 1'b0;
    bus.noise_estimation_en = 1'b1;
    bus.data_in             = '0;
    bus.data_valid          = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_block_mean", int'(bus.block_mean), 0);
    chk("rst_block_var", int'(bus.block_var), 0);
    chk("rst_block_valid", int'(bus.block_valid), 0);
    chk("rst_noise_var", int'(bus.noise_var), 0);
    chk("rst_noise_valid", int'(bus.noise_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8x8 contiguous, with latency check on the first block
    push_8x8();
    sof(8, 8);
    chk("busy_after_sof", int'(bus.busy), 1);
    for (int i = 1; i <= 16; i++) beat(i);
    beat16_cyc = cyc;
    for (int i = 17; i <= 20; i++) beat(i);
    chk("block_latency", last_bv_cyc - beat16_cyc, 2);
    for (int i = 21; i <= 64; i++) beat(i);
    drain();
    chk("busy_after_frame", int'(bus.busy), 0);

    // Constant block in a 4x4 frame
    push_blk(5, 0);
    push_noise(0, 1'b1);
    sof(4, 4);
    for (int i = 1; i <= 16; i++) beat(5);
    drain();

    // Gaps and enable pauses must not change the results
    push_8x8();
    sof(8, 8);
    for (int i = 1; i <= 64; i++) begin
      if (i == 6) paused(3);
      if (i % 5 == 0) idle(2);
      beat(i);
    end
    drain();

    // Abort after 20 beats, then a full frame
    push_blk(8, 29);
    sof(8, 8);
    for (int i = 1; i <= 20; i++) beat(i);
    idle(3);
    push_8x8();
    sof(8, 8);
    for (int i = 1; i <= 64; i++) beat(i);
    drain();

    // Asynchronous reset mid-block clears outputs immediately
    sof(4, 4);
    for (int i = 1; i <= 10; i++) beat(i);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_block_mean", int'(bus.block_mean), 0);
    chk("midrst_block_var", int'(bus.block_var), 0);
    chk("midrst_noise_var", int'(bus.noise_var), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_blk(8, 29);
    push_noise(29, 1'b1);
    sof(4, 4);
    for (int i = 1; i <= 16; i++) beat(i);
    drain();

    // Frame smaller than one block: immediate noise result of 0
    push_noise(0, 1'b0);
    sof(2, 8);
    drain();

    // 6x5 frame floors to one block; extra beats afterwards ignored
    push_blk(8, 29);
    push_noise(29, 1'b1);
    sof(6, 5);
    for (int i = 1; i <= 16; i++) beat(i);
    for (int i = 0; i < 4; i++) beat(255);
    drain();
    chk("idle_busy_end", int'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
